// File: rtl/pwm_fade_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_pkg
//  Description : Shared widths, state encoding and the step-rate rule for
//                the PWM fade sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

  // Default widths; the duty width tracks the PWM counter it drives.
  localparam int DEF_DUTY_W = 8;
  localparam int DEF_RATE_W = 16;

  // Sequencer state encoding (kept as plain constants for legacy tools).
  localparam int STATE_W = 2;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RAMP    = 2'd1;
  localparam logic [1:0] BR_UP   = 2'd2;
  localparam logic [1:0] BR_DOWN = 2'd3;

  typedef logic [STATE_W-1:0] state_t;

  // A zero rate would mean "never step"; it is promoted to one step per clock.
  function automatic int unsigned eff_rate(input int unsigned rate);
    return (rate == 0) ? 32'd1 : rate;
  endfunction

endpackage : pwm_ctrl_pkg
`default_nettype wire

// File: rtl/pwm_fade_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fade_ctrl_if
//  Description : Command handshake between the control logic (master) and
//                the fade sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_fade_ctrl_if
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int RATE_W = DEF_RATE_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_target;
  logic [RATE_W-1:0] cmd_rate;
  logic              cmd_mode;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_rate,
    output cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_rate,
    input  cmd_mode,
    output cmd_ready
  );

endinterface : pwm_fade_ctrl_if
`default_nettype wire

// File: rtl/pwm_fade_ctrl_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_timer
//  Description : Down-counting step timer. Emits one tick every `period`
//                clocks after a load; clr holds it idle at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
  parameter int RATE_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load,
  input  wire logic              clr,
  input  wire logic [RATE_W-1:0] period,
  output logic                   tick
);

  logic [RATE_W-1:0] r_count;
  logic [RATE_W-1:0] w_reload;

  // period is never zero here (the caller applies the 0->1 rule).
  assign w_reload = period - RATE_W'(1);

  // Tick on the last cycle of each period; load/clr take precedence.
  assign tick = (r_count == '0) && !clr && !load;

  // Count down, reloading on load and after every tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load || tick) begin
      r_count <= w_reload;
    end else begin
      r_count <= r_count - RATE_W'(1);
    end
  end

endmodule : step_timer
`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fade_ctrl
//  Description : Ramp / breathe sequencer for the PWM duty_cycle input.
//                Steps the duty value by +/-1 every `rate` clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int RATE_W = DEF_RATE_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pwm_fade_ctrl_if.slave   cmd,
  input  wire logic        abort,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic             busy,
  output logic             done
);

  state_t            r_state;
  logic [DUTY_W-1:0] r_duty;
  logic              r_done;
  logic [DUTY_W-1:0] r_target;
  logic [RATE_W-1:0] r_rate;
  logic              r_breathe;

  logic              w_accept;
  logic              w_breathe;
  logic [RATE_W-1:0] w_eff_rate;
  logic [RATE_W-1:0] w_period;
  logic              w_tick;
  logic              w_tmr_clr;
  logic [DUTY_W-1:0] w_duty_inc;
  logic [DUTY_W-1:0] w_duty_dec;
  logic [DUTY_W-1:0] w_ramp_next;

  assign cmd.cmd_ready = (r_state == IDLE) && !abort;
  assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

  // Breathing towards zero has no upper endpoint, so it degrades to a ramp.
  assign w_breathe  = cmd.cmd_mode && (cmd.cmd_target != '0);
  assign w_eff_rate = RATE_W'(eff_rate(32'(cmd.cmd_rate)));

  // The timer needs the incoming rate on the accept cycle, the latched one after.
  assign w_period  = w_accept ? w_eff_rate : r_rate;
  assign w_tmr_clr = abort || ((r_state == IDLE) && !w_accept);

  assign w_duty_inc  = r_duty + DUTY_W'(1);
  assign w_duty_dec  = r_duty - DUTY_W'(1);
  assign w_ramp_next = (r_duty < r_target) ? w_duty_inc : w_duty_dec;

  step_timer #(
    .RATE_W (RATE_W)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .clr    (w_tmr_clr),
    .period (w_period),
    .tick   (w_tick)
  );

  // Sequencer: command latch, state transitions and the duty register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_duty    <= '0;
      r_done    <= 1'b0;
      r_target  <= '0;
      r_rate    <= RATE_W'(1);
      r_breathe <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        // Freeze duty where it is; no done, timer cleared via w_tmr_clr.
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_target  <= cmd.cmd_target;
              r_rate    <= w_eff_rate;
              r_breathe <= w_breathe;
              if (!w_breathe) begin
                if (cmd.cmd_target == r_duty) begin
                  r_done <= 1'b1;
                end else begin
                  r_state <= RAMP;
                end
              end else if (r_duty < cmd.cmd_target) begin
                r_state <= BR_UP;
              end else begin
                r_state <= BR_DOWN;
              end
            end
          end
          RAMP: begin
            if (w_tick) begin
              r_duty <= w_ramp_next;
              if (w_ramp_next == r_target) begin
                r_state <= IDLE;
                r_done  <= !r_breathe;
              end
            end
          end
          BR_UP: begin
            if (w_tick) begin
              r_duty <= w_duty_inc;
              if (w_duty_inc == r_target) begin
                r_state <= BR_DOWN;
              end
            end
          end
          BR_DOWN: begin
            if (w_tick) begin
              r_duty <= w_duty_dec;
              if (w_duty_dec == '0) begin
                r_state <= BR_UP;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign duty_cycle = r_duty;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);

endmodule : pwm_fade_ctrl
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_fade_ctrl
//  Description : Self-checking bench for pwm_fade_ctrl: table-driven ramps,
//                hand-written corner sequences and randomized commands
//                checked against a closed-form trajectory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_ctrl;

  logic       clk;
  logic       rst;
  logic       abort;
  logic [7:0] duty_cycle;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;
  int cur_duty;

  pwm_fade_ctrl_if #(.DUTY_W(8), .RATE_W(16)) cmd_if ();

  pwm_fade_ctrl #(
    .DUTY_W (8),
    .RATE_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .abort      (abort),
    .duty_cycle (duty_cycle),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int target;
    int rate;
    int mode;
    int exp_final;
    int exp_done_k;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---- reference model: closed-form trajectory k cycles after acceptance ----
  function automatic int m_rate(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic bit m_is_ramp(input int t, input int m);
    return (m == 0) || (t == 0);
  endfunction

  function automatic int m_dist(input int d0, input int t);
    return (t >= d0) ? (t - d0) : (d0 - t);
  endfunction

  function automatic int m_duty(input int d0, input int t, input int r, input int m, input int k);
    int s;
    int p;
    s = k / m_rate(r);
    if (m_is_ramp(t, m)) begin
      if (s > m_dist(d0, t)) s = m_dist(d0, t);
      return (t >= d0) ? d0 + s : d0 - s;
    end
    if (d0 < t) begin
      if (s <= t - d0) return d0 + s;
      p = (s - (t - d0)) % (2 * t);
      return (p <= t) ? t - p : p - t;
    end
    if (s <= d0) return d0 - s;
    p = (s - d0) % (2 * t);
    return (p <= t) ? p : 2 * t - p;
  endfunction

  function automatic int m_done(input int d0, input int t, input int r, input int m, input int k);
    if (!m_is_ramp(t, m)) return 0;
    return (k == m_dist(d0, t) * m_rate(r)) ? 1 : 0;
  endfunction

  function automatic int m_busy(input int d0, input int t, input int r, input int m, input int k);
    if (!m_is_ramp(t, m)) return 1;
    return (k < m_dist(d0, t) * m_rate(r)) ? 1 : 0;
  endfunction

  // Present a command for one edge; leaves time at 1 ns after the accept edge.
  task automatic issue(input int t, input int r, input int m);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'(t);
    cmd_if.cmd_rate   = 16'(r);
    cmd_if.cmd_mode   = m[0];
    #1;
    chk("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Compare every cycle k = 0..ncyc against the model; report first done cycle.
  task automatic follow(input int d0, input int t, input int r, input int m,
                        input int ncyc, output int done_k);
    done_k = -1;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("duty", 32'(duty_cycle), 32'(m_duty(d0, t, r, m, k)));
      chk("done", 32'(done), 32'(m_done(d0, t, r, m, k)));
      chk("busy", 32'(busy), 32'(m_busy(d0, t, r, m, k)));
      if (done && done_k < 0) done_k = k;
    end
  endtask

  task automatic run_ramp(input int t, input int r);
    int dk;
    int d0;
    d0 = cur_duty;
    issue(t, r, 0);
    follow(d0, t, r, 0, m_dist(d0, t) * m_rate(r) + 2, dk);
    cur_duty = t;
  endtask

  task automatic do_abort(input int frozen);
    abort = 1'b1;
    #1;
    chk("ready_during_abort", 32'(cmd_if.cmd_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_duty", 32'(duty_cycle), 32'(frozen));
      chk("abort_done", 32'(done), 32'd0);
    end
    abort = 1'b0;
    #1;
    chk("ready_after_abort", 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  initial begin
    int dk;
    int exp_seq[10];
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    abort   = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_rate   = '0;
    cmd_if.cmd_mode   = 1'b0;

    vecs[0] = '{target: 10, rate: 3, mode: 0, exp_final: 10, exp_done_k: 30};
    vecs[1] = '{target: 10, rate: 5, mode: 0, exp_final: 10, exp_done_k: 0};
    vecs[2] = '{target: 3,  rate: 0, mode: 0, exp_final: 3,  exp_done_k: 7};
    vecs[3] = '{target: 20, rate: 2, mode: 0, exp_final: 20, exp_done_k: 34};
    vecs[4] = '{target: 0,  rate: 1, mode: 1, exp_final: 0,  exp_done_k: 20};
    vecs[5] = '{target: 6,  rate: 4, mode: 0, exp_final: 6,  exp_done_k: 24};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset_duty", 32'(duty_cycle), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ready", 32'(cmd_if.cmd_ready), 32'd1);
    rst = 1'b0;
    cur_duty = 0;
    @(posedge clk);
    #1;

    // ---------------- table-driven ramps ----------------
    for (int i = 0; i < 6; i++) begin
      int d0;
      d0 = cur_duty;
      issue(vecs[i].target, vecs[i].rate, vecs[i].mode);
      follow(d0, vecs[i].target, vecs[i].rate, vecs[i].mode, vecs[i].exp_done_k + 2, dk);
      chk("vec_done_cycle", 32'(dk), 32'(vecs[i].exp_done_k));
      chk("vec_final_duty", 32'(duty_cycle), 32'(vecs[i].exp_final));
      chk("vec_ready_after", 32'(cmd_if.cmd_ready), 32'd1);
      cur_duty = vecs[i].exp_final;
    end

    // ---------------- breathe t=4 rate=1 from 0, then abort ----------------
    run_ramp(0, 0);
    exp_seq = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    issue(4, 1, 1);
    chk("breathe_busy_k0", 32'(busy), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("breathe_seq", 32'(duty_cycle), 32'(exp_seq[k]));
      chk("breathe_no_done", 32'(done), 32'd0);
    end
    do_abort(2);
    cur_duty = 2;

    // ---------------- full-scale ramp at rate 0 ----------------
    run_ramp(0, 1);
    issue(255, 0, 0);
    follow(0, 255, 0, 0, 258, dk);
    chk("full_done_cycle", 32'(dk), 32'd255);
    chk("full_final", 32'(duty_cycle), 32'd255);
    cur_duty = 255;

    // ---------------- abort beats cmd_valid in IDLE ----------------
    abort = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'd100;
    cmd_if.cmd_rate   = 16'd1;
    cmd_if.cmd_mode   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_vs_valid_busy", 32'(busy), 32'd0);
      chk("abort_vs_valid_duty", 32'(duty_cycle), 32'd255);
      chk("abort_vs_valid_done", 32'(done), 32'd0);
    end
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_vs_valid_idle", 32'(busy), 32'd0);

    // ---------------- asynchronous reset mid-ramp ----------------
    issue(200, 1, 0);
    follow(255, 200, 1, 0, 5, dk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_duty", 32'(duty_cycle), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_duty", 32'(duty_cycle), 32'd0);
    cur_duty = 0;
    @(posedge clk);
    #1;

    // ---------------- cmd_valid held during RAMP ----------------
    issue(5, 1, 0);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'd2;
    cmd_if.cmd_rate   = 16'd2;
    cmd_if.cmd_mode   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("held_duty", 32'(duty_cycle), 32'(k));
      chk("held_ready", 32'(cmd_if.cmd_ready), (k == 5) ? 32'd1 : 32'd0);
      chk("held_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    follow(5, 2, 2, 0, 8, dk);
    chk("held_done_cycle", 32'(dk), 32'd6);
    chk("held_final", 32'(duty_cycle), 32'd2);
    cur_duty = 2;

    // ---------------- randomized commands vs model ----------------
    for (int it = 0; it < 25; it++) begin
      int m;
      int r;
      int t;
      int d0;
      int n;
      m  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 3));
      d0 = cur_duty;
      if (m == 0) begin
        t = d0 + int'($urandom_range(0, 60)) - 30;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
      end else begin
        t = int'($urandom_range(0, 12));
      end
      issue(t, r, m);
      if (m_is_ramp(t, m)) begin
        follow(d0, t, r, m, m_dist(d0, t) * m_rate(r) + 2, dk);
        cur_duty = t;
      end else begin
        n = int'($urandom_range(5, 60));
        follow(d0, t, r, m, n, dk);
        chk("rand_breathe_no_done", 32'(dk), 32'hFFFF_FFFF);
        cur_duty = m_duty(d0, t, r, m, n);
        do_abort(cur_duty);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pwm_fade_ctrl
`default_nettype wire
